// File: rtl/window_gen_3x3.sv
// window_gen_3x3: turns a raster-scan 8-bit pixel stream into 3x3 neighbourhoods.
// One window is emitted, one cycle after each accepted pixel, once that pixel sits at row >= 2
// and column >= 2. The window is centred on (row-1, col-1), so only interior centres appear.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   pix_in     - grayscale input pixel
//   pix_valid  - pix_in valid this cycle (no backpressure)
//   sof        - with pix_valid: this pixel is (0,0)
//   px0..px8   - window, row-major; px4 = centre, px8 = newest pixel
//   win_valid  - window/win_x/win_y valid (1-cycle pulse)
//   win_x/y    - centre column/row
//   frame_done - pulse after the last pixel of a frame is accepted
//   sof_err    - pulse when sof arrives mid-frame (the frame restarts)
module window_gen_3x3 #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned XW         = $clog2(IMG_WIDTH),
  parameter int unsigned YW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  input  logic          sof,
  output logic [7:0]    px0,
  output logic [7:0]    px1,
  output logic [7:0]    px2,
  output logic [7:0]    px3,
  output logic [7:0]    px4,
  output logic [7:0]    px5,
  output logic [7:0]    px6,
  output logic [7:0]    px7,
  output logic [7:0]    px8,
  output logic          win_valid,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          frame_done,
  output logic          sof_err
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e          r_state, w_state_nxt;
  logic [XW-1:0]   r_col, w_col_nxt, w_c;
  logic [YW-1:0]   r_row, w_row_nxt, w_r;
  logic            w_accept, w_last, w_emit;

  logic [7:0]      r_lb0 [IMG_WIDTH];  // row r-1
  logic [7:0]      r_lb1 [IMG_WIDTH];  // row r-2
  logic [7:0]      r_win [9];

  logic            r_win_valid, r_frame_done, r_sof_err;
  logic [XW-1:0]   r_win_x;
  logic [YW-1:0]   r_win_y;

  always_comb begin
    w_accept = pix_valid && ((r_state == StActive) || sof);
    // sof forces the position to (0,0) both when starting and when restarting a frame.
    w_c      = sof ? '0 : r_col;
    w_r      = sof ? '0 : r_row;
    w_last   = (w_r == YW'(IMG_HEIGHT - 1)) && (w_c == XW'(IMG_WIDTH - 1));
    w_emit   = w_accept && (w_r >= YW'(2)) && (w_c >= XW'(2));

    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    if (w_accept) begin
      if (w_last) begin
        w_state_nxt = StIdle;
        w_col_nxt   = '0;
        w_row_nxt   = '0;
      end else begin
        w_state_nxt = StActive;
        if (w_c == XW'(IMG_WIDTH - 1)) begin
          w_col_nxt = '0;
          w_row_nxt = w_r + YW'(1);
        end else begin
          w_col_nxt = w_c + XW'(1);
          w_row_nxt = w_r;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= '{default: '0};
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
      r_win_x      <= '0;
      r_win_y      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_win_valid  <= w_emit;
      r_frame_done <= w_accept && w_last;
      r_sof_err    <= pix_valid && sof && (r_state == StActive);
      if (w_accept) begin
        // Shift columns left; new right column is {row r-2, row r-1, current}.
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= r_lb1[w_c];
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= r_lb0[w_c];
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= pix_in;
      end
      if (w_emit) begin
        r_win_x <= w_c - XW'(1);
        r_win_y <= w_r - YW'(1);
      end
    end
  end

  // Line buffers carry no reset; stale contents are never emitted because windows need r,c >= 2.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_lb1[w_c] <= r_lb0[w_c];
      r_lb0[w_c] <= pix_in;
    end
  end

  assign px0        = r_win[0];
  assign px1        = r_win[1];
  assign px2        = r_win[2];
  assign px3        = r_win[3];
  assign px4        = r_win[4];
  assign px5        = r_win[5];
  assign px6        = r_win[6];
  assign px7        = r_win[7];
  assign px8        = r_win[8];
  assign win_valid  = r_win_valid;
  assign win_x      = r_win_x;
  assign win_y      = r_win_y;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 with a 4x4 image; pixel value = base + 16*row + col.
module tb_window_gen_3x3;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          sof;
  logic [7:0]    px [9];
  logic          win_valid;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          frame_done;
  logic          sof_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .px0(px[0]), .px1(px[1]), .px2(px[2]), .px3(px[3]), .px4(px[4]),
    .px5(px[5]), .px6(px[6]), .px7(px[7]), .px8(px[8]),
    .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic cycle(input logic v, input logic s, input logic [7:0] p);
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      chk("idle_win_valid", 32'(win_valid), 0);
      chk("idle_frame_done", 32'(frame_done), 0);
      chk("idle_sof_err", 32'(sof_err), 0);
    end
  endtask

  // Send pixel (r,c) of a frame and check everything the next cycle must show.
  task automatic send_pix(input int r, input int c, input int base, input logic s,
                          input logic exp_err);
    logic exp_win;
    exp_win = (r >= 2) && (c >= 2);
    cycle(1'b1, s, 8'(base + 16 * r + c));
    chk("win_valid", 32'(win_valid), 32'(exp_win));
    chk("frame_done", 32'(frame_done), 32'((r == H - 1) && (c == W - 1)));
    chk("sof_err", 32'(sof_err), 32'(exp_err));
    if (exp_win) begin
      for (int k = 0; k < 9; k++)
        chk($sformatf("px%0d@(%0d,%0d)", k, r, c), 32'(px[k]),
            32'(base + 16 * (r - 2 + k / 3) + (c - 2 + k % 3)));
      chk("win_x", 32'(win_x), 32'(c - 1));
      chk("win_y", 32'(win_y), 32'(r - 1));
    end
  endtask

  task automatic send_frame(input int base, input int max_gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        send_pix(r, c, base, (r == 0) && (c == 0), 1'b0);
      end
  endtask

  initial begin
    rst = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h55);
    chk("rst_win_valid", 32'(win_valid), 0);
    chk("rst_px4", 32'(px[4]), 0);
    chk("rst_win_x", 32'(win_x), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    rst = 1'b0;
    idle(2);

    // Gapless frame.
    send_frame(0, 0);
    idle(2);

    // Same frame with random gaps.
    send_frame(0, 3);
    idle(2);

    // Pixels without sof in IDLE are dropped.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 8'hEE);
      chk("presof_win_valid", 32'(win_valid), 0);
    end
    send_frame(0, 0);
    idle(1);

    // sof on the 7th pixel restarts the frame.
    for (int i = 0; i < 6; i++) send_pix(i / W, i % W, 8'h90, (i == 0), 1'b0);
    for (int i = 0; i < 16; i++) send_pix(i / W, i % W, 0, (i == 0), (i == 0));
    idle(1);

    // Reset mid row 2, right after a window was emitted at (2,2).
    for (int i = 0; i < 11; i++) send_pix(i / W, i % W, 0, (i == 0), 1'b0);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'h23);
    rst = 1'b0;
    chk("midrst_win_valid", 32'(win_valid), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("midrst_px%0d", k), 32'(px[k]), 0);
    chk("midrst_win_x", 32'(win_x), 0);
    chk("midrst_win_y", 32'(win_y), 0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 8'h77);
      chk("postrst_win_valid", 32'(win_valid), 0);
    end
    send_frame(8'h40, 0);
    idle(1);

    // Back-to-back frames: no sof_err, no leakage from the first frame.
    send_frame(0, 0);
    send_frame(8'h80, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
